// File: rtl/lifo_frame_reverser.sv
// Stream front-end for an unregistered LIFO: it buffers each frame (or each DEPTH-word
// segment of a longer frame), then replays it in reverse word order through a registered output.
module lifo_frame_reverser #(
    parameter int DEPTH      = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  reset_ni,
    input  logic                  s_valid_i,
    input  logic [DATA_WIDTH-1:0] s_data_i,
    input  logic                  s_last_i,
    output logic                  s_ready_o,
    output logic                  m_valid_o,
    output logic [DATA_WIDTH-1:0] m_data_o,
    output logic                  m_last_o,
    input  logic                  m_ready_i,
    output logic                  lifo_push_o,
    output logic [DATA_WIDTH-1:0] lifo_push_data_o,
    output logic                  lifo_pop_o,
    input  logic [DATA_WIDTH-1:0] lifo_pop_data_i,
    input  logic                  lifo_empty_i,
    input  logic                  lifo_full_i,
    output logic                  seg_o
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        FILL,
        DRAIN
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic          fill_ends;

    // Push and pop are confined to different states, so they can never coincide.
    assign s_ready_o        = (state_r == FILL) && !lifo_full_i && (cnt_r != CNT_FULL);
    assign lifo_push_o      = s_valid_i && s_ready_o;
    assign lifo_push_data_o = s_data_i;
    assign lifo_pop_o       = (state_r == DRAIN) && (cnt_r != '0) && !lifo_empty_i
                              && (!m_valid_o || m_ready_i);
    assign fill_ends        = lifo_push_o && (s_last_i || (cnt_r == CNT_LAST));
    assign seg_o            = lifo_push_o && !s_last_i && (cnt_r == CNT_LAST);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_r   <= FILL;
            cnt_r     <= '0;
            m_valid_o <= 1'b0;
            m_data_o  <= '0;
            m_last_o  <= 1'b0;
        end else begin
            if (lifo_push_o) begin
                cnt_r <= cnt_r + CNT_ONE;
            end else if (lifo_pop_o) begin
                cnt_r <= cnt_r - CNT_ONE;
            end

            case (state_r)
                FILL: begin
                    if (fill_ends) begin
                        state_r <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (lifo_pop_o && (cnt_r == CNT_ONE)) begin
                        state_r <= FILL;
                    end
                end
                default: state_r <= FILL;
            endcase

            // The last drained beat may linger into FILL until the consumer takes it.
            if (lifo_pop_o) begin
                m_data_o  <= lifo_pop_data_i;
                m_valid_o <= 1'b1;
                m_last_o  <= (cnt_r == CNT_ONE);
            end else if (m_ready_i) begin
                m_valid_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lifo_frame_reverser.sv
// Directed bench for lifo_frame_reverser with a behavioural LIFO and an output scoreboard.
module tb_lifo_frame_reverser;

    localparam int DEPTH = 4;
    localparam int DW    = 8;

    logic          clk_i = 1'b0;
    logic          reset_ni = 1'b0;
    logic          s_valid_i = 1'b0;
    logic [DW-1:0] s_data_i = '0;
    logic          s_last_i = 1'b0;
    logic          s_ready_o;
    logic          m_valid_o;
    logic [DW-1:0] m_data_o;
    logic          m_last_o;
    logic          m_ready_i = 1'b1;
    logic          lifo_push_o;
    logic [DW-1:0] lifo_push_data_o;
    logic          lifo_pop_o;
    logic [DW-1:0] lifo_pop_data_i;
    logic          lifo_empty_i;
    logic          lifo_full_i;
    logic          seg_o;

    int checks = 0;
    int failures = 0;
    int seg_seen = 0;
    int seg_exp = 0;

    logic [DW-1:0] frame_q[$];
    logic [DW:0]   sb_q[$];

    logic [DW-1:0] mem[0:DEPTH-1];
    logic [2:0]    lcnt;

    always #5 clk_i = ~clk_i;

    lifo_frame_reverser #(.DEPTH(DEPTH), .DATA_WIDTH(DW)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni),
        .s_valid_i(s_valid_i), .s_data_i(s_data_i), .s_last_i(s_last_i), .s_ready_o(s_ready_o),
        .m_valid_o(m_valid_o), .m_data_o(m_data_o), .m_last_o(m_last_o), .m_ready_i(m_ready_i),
        .lifo_push_o(lifo_push_o), .lifo_push_data_o(lifo_push_data_o),
        .lifo_pop_o(lifo_pop_o), .lifo_pop_data_i(lifo_pop_data_i),
        .lifo_empty_i(lifo_empty_i), .lifo_full_i(lifo_full_i), .seg_o(seg_o)
    );

    // Behavioural LIFO with a combinational top-of-stack, reset alongside the DUT.
    always @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            lcnt <= '0;
        end else if (lifo_push_o && (lcnt < 3'(DEPTH))) begin
            mem[2'(lcnt)] <= lifo_push_data_o;
            lcnt <= lcnt + 3'd1;
        end else if (lifo_pop_o && (lcnt != 3'd0)) begin
            lcnt <= lcnt - 3'd1;
        end
    end
    assign lifo_pop_data_i = (lcnt != 3'd0) ? mem[2'(lcnt - 3'd1)] : '0;
    assign lifo_empty_i    = (lcnt == 3'd0);
    assign lifo_full_i     = (lcnt == 3'(DEPTH));

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Per-cycle monitor: scoreboard compare, handshake stability and pulse rules.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_data;
    logic          prev_last;
    logic [DW:0]   exp_beat;

    always @(negedge clk_i) begin
        if (reset_ni) begin
            check_output("push_pop_exclusive", {31'b0, lifo_push_o && lifo_pop_o}, 32'd0);
            check_output("seg_pulse", {31'b0, seg_o},
                         {31'b0, lifo_push_o && !s_last_i && (lcnt == 3'(DEPTH - 1))});
            if (seg_o) seg_seen++;
            if (lifo_pop_o) check_output("pop_when_empty", {29'b0, lcnt}, (lcnt == 3'd0) ? 32'hFFFF : {29'b0, lcnt});
            if (prev_stall) begin
                check_output("stall_valid", {31'b0, m_valid_o}, 32'd1);
                check_output("stall_data", {24'b0, m_data_o}, {24'b0, prev_data});
                check_output("stall_last", {31'b0, m_last_o}, {31'b0, prev_last});
            end
            if (m_valid_o && !m_ready_i) begin
                check_output("pop_while_stalled", {31'b0, lifo_pop_o}, 32'd0);
            end
            if (m_valid_o && m_ready_i) begin
                if (sb_q.size() == 0) begin
                    check_output("unexpected_beat", {24'b0, m_data_o}, 32'hDEAD);
                end else begin
                    exp_beat = sb_q.pop_front();
                    check_output("out_data", {24'b0, m_data_o}, {24'b0, exp_beat[DW-1:0]});
                    check_output("out_last", {31'b0, m_last_o}, {31'b0, exp_beat[DW]});
                end
            end
            prev_stall = m_valid_o && !m_ready_i;
            prev_data  = m_data_o;
            prev_last  = m_last_o;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // Queues the reversed per-segment expectation, then offers frame_q beat by beat.
    task automatic apply_stimulus();
        int n = frame_q.size();
        int e;
        int waited;
        for (int s = 0; s < n; s += DEPTH) begin
            e = (s + DEPTH < n) ? s + DEPTH : n;
            for (int i = e - 1; i >= s; i--) sb_q.push_back({(i == s), frame_q[i]});
            if (e < n) seg_exp++;
        end
        for (int i = 0; i < n; i++) begin
            s_valid_i = 1'b1;
            s_data_i  = frame_q[i];
            s_last_i  = (i == n - 1);
            waited    = 0;
            forever begin
                @(negedge clk_i);
                if (s_ready_o) break;
                waited++;
                if (waited > 100) begin
                    check_output("s_ready_timeout", 32'd0, 32'd1);
                    break;
                end
            end
            @(posedge clk_i);
            #1;
        end
        s_valid_i = 1'b0;
        s_last_i  = 1'b0;
    endtask

    task automatic wait_drain();
        int k = 0;
        forever begin
            @(negedge clk_i);
            if (sb_q.size() == 0) break;
            k++;
            if (k > 200) begin
                check_output("drain_timeout", sb_q.size(), 32'd0);
                break;
            end
        end
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        logic [3:0] pat;
        pat = 4'b1001;

        #2;
        check_output("rst_s_ready", {31'b0, s_ready_o}, 32'd1);
        check_output("rst_m_valid", {31'b0, m_valid_o}, 32'd0);
        check_output("rst_m_data", {24'b0, m_data_o}, 32'd0);
        check_output("rst_m_last", {31'b0, m_last_o}, 32'd0);
        check_output("rst_seg", {31'b0, seg_o}, 32'd0);
        check_output("rst_pop", {31'b0, lifo_pop_o}, 32'd0);
        check_output("rst_push", {31'b0, lifo_push_o}, 32'd0);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        @(posedge clk_i);
        #1;

        $display("[TB] short frame");
        frame_q = '{8'h0A, 8'h0B, 8'h0C};
        apply_stimulus();
        @(negedge clk_i);
        check_output("short_t1_valid", {31'b0, m_valid_o}, 32'd0);
        check_output("short_t1_pop", {31'b0, lifo_pop_o}, 32'd1);
        @(negedge clk_i);
        check_output("short_t2_data", {m_valid_o, 23'b0, m_data_o}, {1'b1, 23'b0, 8'h0C});
        @(negedge clk_i);
        @(negedge clk_i);
        check_output("short_t4_last", {m_valid_o, m_last_o, 22'b0, m_data_o}, {2'b11, 22'b0, 8'h0A});
        check_output("short_turnaround", {31'b0, s_ready_o}, 32'd1);
        wait_drain();

        $display("[TB] single-word frame");
        frame_q = '{8'h0D};
        apply_stimulus();
        @(negedge clk_i);
        @(negedge clk_i);
        check_output("single_out", {m_valid_o, m_last_o, 22'b0, m_data_o}, {2'b11, 22'b0, 8'h0D});
        check_output("single_cnt", {29'b0, lcnt}, 32'd0);
        check_output("single_ready", {31'b0, s_ready_o}, 32'd1);
        wait_drain();

        $display("[TB] overflow split");
        frame_q = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05};
        apply_stimulus();
        wait_drain();
        check_output("split_seg_count", seg_seen, seg_exp);

        $display("[TB] backpressure");
        frame_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        apply_stimulus();
        for (int k = 0; k < 60 && sb_q.size() != 0; k++) begin
            m_ready_i = pat[k % 4];
            @(posedge clk_i);
            #1;
        end
        m_ready_i = 1'b1;
        wait_drain();

        $display("[TB] back-to-back frames");
        frame_q = '{8'h58, 8'h59};
        apply_stimulus();
        frame_q = '{8'h50, 8'h51};
        apply_stimulus();
        wait_drain();

        $display("[TB] reset while draining");
        frame_q = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17};
        apply_stimulus();
        @(negedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b0;
        sb_q.delete();
        #1;
        check_output("rst_drain_valid", {31'b0, m_valid_o}, 32'd0);
        check_output("rst_drain_ready", {31'b0, s_ready_o}, 32'd1);
        check_output("rst_drain_lifo", {29'b0, lcnt}, 32'd0);
        @(posedge clk_i);
        #1;
        reset_ni = 1'b1;
        frame_q = '{8'h0E, 8'h0F};
        apply_stimulus();
        wait_drain();
        repeat (4) @(posedge clk_i);
        #1;

        check_output("scoreboard_empty", sb_q.size(), 32'd0);
        check_output("seg_total", seg_seen, seg_exp);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lifo_frame_reverser.md
# lifo_frame_reverser

Stream-side controller placed directly in front of a `lifo` instance with `OUTPUT_REGISTER = 0`.
- Accepts a valid/ready input stream delimited by `s_last_i` and pushes each beat into the LIFO.
- On frame end, or when the LIFO fills, drains the LIFO through a registered valid/ready output, so each frame or segment leaves in reversed word order.
- Owns the push/pop sequencing and guarantees the LIFO never sees push and pop in the same cycle.

## Interface
Parameters:
- `DEPTH`, 32: capacity of the attached LIFO in words; must match the LIFO instance.
- `DATA_WIDTH`, 32: word width.

Ports. One clock; reset is asynchronous and active-low. The LIFO's active-high `reset_i` is driven by `~reset_ni`, so both reset together.
- `clk_i`  in  1: clock, rising edge.
- `reset_ni`  in  1: asynchronous active-low reset.
- `s_valid_i`  in  1: input beat valid.
- `s_data_i`  in  DATA_WIDTH: input word.
- `s_last_i`  in  1: final beat of the frame.
- `s_ready_o`  out  1: input beat accepted when high together with `s_valid_i`.
- `m_valid_o`  out  1: output beat valid (registered).
- `m_data_o`  out  DATA_WIDTH: output word (registered).
- `m_last_o`  out  1: final beat of the frame or segment (registered).
- `m_ready_i`  in  1: downstream accepts the beat.
- `lifo_push_o`  out  1: to LIFO `push_i`.
- `lifo_push_data_o`  out  DATA_WIDTH: to LIFO `push_data_i`; equals `s_data_i`.
- `lifo_pop_o`  out  1: to LIFO `pop_i`.
- `lifo_pop_data_i`  in  DATA_WIDTH: from LIFO `pop_data_o`; combinational top-of-stack.
- `lifo_empty_i`, `lifo_full_i`  in  1 each: LIFO status.
- `seg_o`  out  1: one-cycle pulse when a frame is split because the LIFO filled.

## Operation
- **State machine:** two states, `FILL` and `DRAIN`. Reset state is `FILL`.
- **Counter `cnt_r`:** width `$clog2(DEPTH)+1`. Tracks LIFO occupancy.
  - +1 on each push, −1 on each pop.
  - Reset value 0.
  - Is authoritative; `lifo_empty_i` / `lifo_full_i` act only as guards.
- **FILL state:**
  - `s_ready_o = !lifo_full_i && (cnt_r != DEPTH)`.
  - Push `lifo_push_o = s_valid_i && s_ready_o`; `lifo_pop_o = 0`.
- **FILL → DRAIN** occurs on a push cycle when either condition holds:
  - `s_last_i = 1`: frame end.
  - `cnt_r == DEPTH-1`, i.e. this push fills the LIFO: segment end. `seg_o` pulses in this cycle unless `s_last_i` is also 1.
- **DRAIN state:**
  - `s_ready_o = 0`.
  - `lifo_pop_o = (cnt_r != 0) && !lifo_empty_i && (!m_valid_o || m_ready_i)`.
  - On a pop: `m_data_o <= lifo_pop_data_i`, `m_valid_o <= 1`, `m_last_o <= (cnt_r == 1)`.
  - On `m_ready_i` without a pop: `m_valid_o <= 0`.
- **DRAIN → FILL** occurs on the pop cycle where `cnt_r == 1`.
  - The output register still holds the last beat after the transition.
  - It is released by `m_ready_i` while FILL pushes proceed; push never touches the output register.
- **Stability:** `m_data_o` and `m_last_o` hold their value while `m_valid_o && !m_ready_i`.
- **Empty frame:** not supported. The frame length is the number of accepted beats, ≥1.
- **Exclusivity:** `lifo_push_o` and `lifo_pop_o` are never high in the same cycle.

## Timing
- **Reset values:** `s_ready_o` is 1 (LIFO empty); `m_valid_o`, `m_data_o`, `m_last_o`, `seg_o`, `lifo_pop_o`, `lifo_push_o` (with `s_valid_i` low) are all 0.
- **Latency:** last beat accepted in cycle T → `DRAIN` in T+1, first pop in T+1 → `m_valid_o` high in T+2 carrying that last beat.
- **Throughput:** one beat per cycle while `m_ready_i` is held high. An N-word frame drains in N cycles; the final beat has `m_last_o = 1` in T+1+N.
- **Turnaround:** final pop in cycle P → `s_ready_o` high in P+1.
- **Backpressure:** with `m_ready_i` low and `m_valid_o` high, no pop occurs and `cnt_r` holds.
- **Reset mid-operation:** asynchronous return to `FILL` with `cnt_r = 0` and the output register cleared. The LIFO is reset together, so no stale words are emitted.
- **Full boundary:** with `DEPTH` words pushed and no `s_last_i`, the next input beat waits with `s_ready_o = 0` until the segment drains. The remaining beats form a new segment, and its final beat carries `m_last_o` on that frame's `s_last_i`.

## Test plan
- **Short frame:** push A,B,C with `s_last_i` on C, `m_ready_i = 1` → outputs C,B,A on consecutive cycles starting 2 cycles after C is accepted; `m_last_o` on A; `s_ready_o` high the cycle after the pop of A.
- **Single-word frame:** D with last → one output D with `m_last_o = 1`; `cnt_r` returns to 0.
- **Overflow split:** `DEPTH = 4`, frame 0..5 with last on 5 → `seg_o` pulse on push of 3; output 3,2,1,0 (last on 0), then 5,4 (last on 4).
- **Backpressure:** frame 1..4 with `m_ready_i` toggling 1,0,0,1,… → order 4,3,2,1 preserved; `m_data_o` stable while stalled; no pop while stalled.
- **Back-to-back frames:** frame X,Y then P,Q presented immediately → output Y,X,Q,P; no push while in DRAIN; push and pop never both high.
- **Reset in DRAIN:** assert `reset_ni = 0` after two pops of an 8-word frame → `m_valid_o = 0`, `s_ready_o = 1` immediately; a new frame E,F then yields F,E only.
